instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// Instruction encoder: turns decoded MIPS-subset instruction fields into
// 32-bit machine words, buffers them in a 4-entry FIFO and streams them
// into instruction memory through a granted write port.
module instr_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [9:0]  base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_last,
    input  logic [3:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    input  logic        im_gnt,
    output logic        im_we,
    output logic [9:0]  im_addr,
    output logic [31:0] im_wdata,
    output logic        done,
    output logic        err,
    output logic [10:0] count
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    state_t      state;
    logic [31:0] word;
    logic        legal;
    logic        accept;
    logic        push;
    logic        pop;
    logic        start_acc;
    logic [31:0] fifo_mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  fill;
    logic        full;
    logic        empty;
    logic [9:0]  cur_addr;

    assign full      = (fill == 3'd4);
    assign empty     = (fill == 3'd0);
    assign in_ready  = (state == S_LOAD) && !full;
    assign accept    = in_valid && in_ready;
    assign legal     = (mnem <= 4'd13);
    assign push      = accept && legal;
    assign pop       = !empty && ((state == S_LOAD) || (state == S_DRAIN)) && im_gnt;
    assign start_acc = (state == S_IDLE) && start;

    // Combinational encoder: build the machine word for the presented fields
    always_comb begin
        word = 32'h0000_0000;
        case (mnem)
            4'd0:  word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100001};
            4'd1:  word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100011};
            4'd2:  word = {6'b000000, rs, rt, rd, 5'b00000, 6'b101010};
            4'd3:  word = {6'b000000, rs, 15'b0, 6'b001000};
            4'd4:  word = 32'h0000_0000;
            4'd5:  word = {6'b001101, rs, rt, imm};
            4'd6:  word = {6'b100011, rs, rt, imm};
            4'd7:  word = {6'b101011, rs, rt, imm};
            4'd8:  word = {6'b000100, rs, rt, imm};
            4'd9:  word = {6'b001111, 5'b00000, rt, imm};
            4'd10: word = {6'b000010, target};
            4'd11: word = {6'b001000, rs, rt, imm};
            4'd12: word = {6'b001001, rs, rt, imm};
            4'd13: word = {6'b000011, target};
            default: word = 32'h0000_0000;
        endcase
    end

    // Session FSM with registered done pulse and sticky illegal flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_LOAD;
                        err   <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (accept && !legal) err <= 1'b1;
                    if (accept && in_last) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (empty) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // FIFO pointers and occupancy; push and pop may share an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            fill   <= 3'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   fill <= fill + 3'd1;
                2'b01:   fill <= fill - 3'd1;
                default: fill <= fill;
            endcase
        end
    end

    // FIFO storage; stale contents are harmless once the pointers reset
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= word;
    end

    // IM write port, address walker and saturating word counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            im_we    <= 1'b0;
            im_addr  <= 10'd0;
            im_wdata <= 32'h0000_0000;
            cur_addr <= 10'd0;
            count    <= 11'd0;
        end else begin
            im_we <= pop;
            if (start_acc) begin
                cur_addr <= base_addr;
                count    <= 11'd0;
            end else if (pop) begin
                im_addr  <= cur_addr;
                im_wdata <= fifo_mem[rd_ptr];
                cur_addr <= cur_addr + 10'd1;
                if (count != 11'd2047) count <= count + 11'd1;
            end
        end
    end

endmodule
